// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: loads ALU operands from a shared switch bank, captures the
// 32-bit ALU result and converts it to packed BCD with a serial double-dabble.
module alu_seq_ctrl #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned RES_W      = 32,
   parameter int unsigned BCD_DIGITS = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_W-1:0]       sw_data,
   input  logic [1:0]              sw_op,
   input  logic                    btn_enter,
   input  logic                    btn_clear,
   output logic [DATA_W-1:0]       alu_a,
   output logic [DATA_W-1:0]       alu_b,
   output logic [1:0]              alu_op,
   input  logic [RES_W-1:0]        alu_result,
   output logic [4*BCD_DIGITS-1:0] bcd_out,
   output logic [2:0]              state_o,
   output logic                    busy,
   output logic                    done,
   output logic                    div_err
);

   localparam int unsigned BCD_W = 4 * BCD_DIGITS;
   localparam int unsigned SH_W  = BCD_W + RES_W;
   localparam int unsigned CNT_W = $clog2(RES_W + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WAIT_B = 3'd1,
      EXEC   = 3'd2,
      CONV   = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t              state_q;
   logic                enter_q;
   logic [DATA_W-1:0]   alu_a_q;
   logic [DATA_W-1:0]   alu_b_q;
   logic [1:0]          alu_op_q;
   logic [RES_W-1:0]    res_q;
   logic [BCD_W-1:0]    bcd_sh_q;
   logic [BCD_W-1:0]    bcd_out_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                busy_q;
   logic                done_q;
   logic                div_err_q;

   logic                press_c;
   logic                div_zero_c;
   logic                last_shift_c;
   logic [BCD_W-1:0]    bcd_adj_c;
   logic [SH_W-1:0]     shift_c;

   // Single-cycle enter pulse on the rising edge of the level button
   assign press_c = btn_enter & ~enter_q;

   // All-ones is the ALU's divide-by-zero marker; no legal quotient reaches it
   assign div_zero_c = (alu_op_q == 2'b11) && (alu_result == {RES_W{1'b1}});

   assign last_shift_c = (cnt_q == CNT_W'(RES_W - 1));

   // Double-dabble correction: add 3 to every digit that would overflow on shift
   always_comb begin
      bcd_adj_c = bcd_sh_q;
      for (int i = 0; i < int'(BCD_DIGITS); i++) begin
         if (bcd_sh_q[4*i +: 4] >= 4'd5) begin
            bcd_adj_c[4*i +: 4] = bcd_sh_q[4*i +: 4] + 4'd3;
         end
      end
   end

   assign shift_c = {bcd_adj_c, res_q} << 1;

   // Sequencer FSM with all operand, result and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         enter_q   <= 1'b0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_op_q  <= '0;
         res_q     <= '0;
         bcd_sh_q  <= '0;
         bcd_out_q <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         div_err_q <= 1'b0;
      end else begin
         enter_q <= btn_enter;
         if (btn_clear) begin
            state_q   <= IDLE;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            bcd_out_q <= '0;
            div_err_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (press_c) begin
                     alu_a_q <= sw_data;
                     state_q <= WAIT_B;
                  end
               end
               WAIT_B: begin
                  if (press_c) begin
                     alu_b_q  <= sw_data;
                     alu_op_q <= sw_op;
                     busy_q   <= 1'b1;
                     state_q  <= EXEC;
                  end
               end
               EXEC: begin
                  res_q <= alu_result;
                  if (div_zero_c) begin
                     div_err_q <= 1'b1;
                     bcd_out_q <= '1;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                     state_q   <= DONE;
                  end else begin
                     div_err_q <= 1'b0;
                     bcd_sh_q  <= '0;
                     cnt_q     <= '0;
                     state_q   <= CONV;
                  end
               end
               CONV: begin
                  {bcd_sh_q, res_q} <= shift_c;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (last_shift_c) begin
                     bcd_out_q <= shift_c[SH_W-1 -: BCD_W];
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                     state_q   <= DONE;
                  end
               end
               DONE: begin
                  if (press_c) begin
                     alu_a_q <= sw_data;
                     done_q  <= 1'b0;
                     state_q <= WAIT_B;
                  end
               end
               default: begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign alu_a   = alu_a_q;
   assign alu_b   = alu_b_q;
   assign alu_op  = alu_op_q;
   assign bcd_out = bcd_out_q;
   assign state_o = state_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign div_err = div_err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a behavioural ALU and BCD model.
module tb_alu_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] sw_data;
   logic [1:0]  sw_op;
   logic        btn_enter;
   logic        btn_clear;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [1:0]  alu_op;
   logic [31:0] alu_result;
   logic [39:0] bcd_out;
   logic [2:0]  state_o;
   logic        busy;
   logic        done;
   logic        div_err;

   int          nvec = 0;
   int          nerr = 0;
   logic [39:0] model_bcd = '0;

   alu_seq_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw_data    (sw_data),
      .sw_op      (sw_op),
      .btn_enter  (btn_enter),
      .btn_clear  (btn_clear),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .bcd_out    (bcd_out),
      .state_o    (state_o),
      .busy       (busy),
      .done       (done),
      .div_err    (div_err)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: add, abs-diff, multiply, max/min divide (all-ones on /0)
   function automatic logic [31:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op);
      logic [31:0] mx, mn;
      case (op)
         2'b00: return 32'(a) + 32'(b);
         2'b01: return (a >= b) ? 32'(a - b) : 32'(b - a);
         2'b10: return 32'(a) * 32'(b);
         default: begin
            mx = (a >= b) ? 32'(a) : 32'(b);
            mn = (a >= b) ? 32'(b) : 32'(a);
            if (mn == 32'd0) return 32'hFFFF_FFFF;
            return mx / mn;
         end
      endcase
   endfunction

   assign alu_result = alu_fn(alu_a, alu_b, alu_op);

   // Decimal digits by repeated division
   function automatic logic [39:0] to_bcd(input logic [31:0] v);
      logic [39:0]    r;
      longint unsigned x;
      r = '0;
      x = longint'(v);
      for (int i = 0; i < 10; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; btn_enter = 1'b0; btn_clear = 1'b0; sw_data = '0; sw_op = '0;
      #12;
      nvec++;
      if ({state_o, alu_a, alu_b, alu_op, bcd_out, div_err, busy, done} !== '0) begin
         nerr++;
         $display("FAIL reset: got st=%0d a=%h b=%h op=%0d bcd=%h err=%b busy=%b done=%b want all 0",
                  state_o, alu_a, alu_b, alu_op, bcd_out, div_err, busy, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      model_bcd = '0;
   endtask

   // Full A/B/op transaction with optional enter pulse injected mid-operation
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                         input int poke_at, input string tag);
      logic [31:0] r;
      logic [39:0] exp_bcd, prev;
      logic        exp_err;
      int          cyc, exp_lat;
      bit          hold_ok;
      r       = alu_fn(a, b, op);
      exp_err = (op == 2'b11) && (r == 32'hFFFF_FFFF);
      exp_bcd = exp_err ? '1 : to_bcd(r);
      exp_lat = exp_err ? 2 : 34;
      prev    = model_bcd;

      sw_data = a; btn_enter = 1'b1; tick(); btn_enter = 1'b0; tick();
      nvec++;
      if (state_o !== 3'd1 || alu_a !== a) begin
         nerr++;
         $display("FAIL %s load_a: got st=%0d a=%h want st=1 a=%h", tag, state_o, alu_a, a);
      end

      sw_data = b; sw_op = op; btn_enter = 1'b1; tick(); btn_enter = 1'b0;
      cyc = 1;
      nvec++;
      if (state_o !== 3'd2 || busy !== 1'b1 || alu_b !== b || alu_op !== op) begin
         nerr++;
         $display("FAIL %s exec: got st=%0d busy=%b b=%h op=%0d want st=2 busy=1 b=%h op=%0d",
                  tag, state_o, busy, alu_b, alu_op, b, op);
      end

      hold_ok = 1'b1;
      while (done !== 1'b1 && cyc < 60) begin
         if (cyc == poke_at) begin
            sw_data = 16'($urandom); btn_enter = 1'b1;
         end else begin
            btn_enter = 1'b0;
         end
         tick();
         cyc++;
         if (done !== 1'b1 && bcd_out !== prev) hold_ok = 1'b0;
      end
      btn_enter = 1'b0;

      nvec++;
      if (cyc != exp_lat) begin
         nerr++;
         $display("FAIL %s latency: got %0d want %0d", tag, cyc, exp_lat);
      end
      nvec++;
      if (bcd_out !== exp_bcd || div_err !== exp_err) begin
         nerr++;
         $display("FAIL %s result: got bcd=%h err=%b want bcd=%h err=%b",
                  tag, bcd_out, div_err, exp_bcd, exp_err);
      end
      nvec++;
      if (state_o !== 3'd4 || busy !== 1'b0 || alu_a !== a || !hold_ok) begin
         nerr++;
         $display("FAIL %s done_state: got st=%0d busy=%b a=%h hold=%b want st=4 busy=0 a=%h hold=1",
                  tag, state_o, busy, alu_a, hold_ok, a);
      end
      model_bcd = exp_bcd;
   endtask

   task automatic test_directed();
      run_op(16'd25,    16'd17,    2'b00, 0, "add25_17");
      run_op(16'd5,     16'd9,     2'b01, 0, "absdiff5_9");
      run_op(16'd100,   16'd7,     2'b11, 0, "div100_7");
      run_op(16'd65535, 16'd65535, 2'b10, 0, "mulmax");
      run_op(16'd1234,  16'd0,     2'b11, 0, "div_zero");
      run_op(16'd1234,  16'd0,     2'b10, 0, "mul_zero");
   endtask

   task automatic test_press_in_conv();
      run_op(16'd4321, 16'd1111, 2'b00, 1,  "poke_exec");
      run_op(16'd999,  16'd3,    2'b10, 12, "poke_conv");
   endtask

   task automatic test_random();
      logic [15:0] a, b;
      logic [1:0]  op;
      for (int i = 0; i < 20; i++) begin
         a  = 16'($urandom);
         b  = ($urandom_range(4, 0) == 0) ? 16'd0 : 16'($urandom);
         op = 2'($urandom);
         run_op(a, b, op, 0, "random");
      end
   endtask

   task automatic test_hold();
      logic [15:0] first;
      btn_clear = 1'b1; tick(); btn_clear = 1'b0; tick();
      model_bcd = '0;
      first = 16'($urandom);
      sw_data = first; sw_op = 2'b00; btn_enter = 1'b1;
      repeat (10) begin
         tick();
         sw_data = 16'($urandom);
      end
      btn_enter = 1'b0; tick();
      nvec++;
      if (state_o !== 3'd1 || alu_a !== first || alu_b !== 16'd0) begin
         nerr++;
         $display("FAIL hold_enter: got st=%0d a=%h b=%h want st=1 a=%h b=0",
                  state_o, alu_a, alu_b, first);
      end
      btn_clear = 1'b1; tick(); btn_clear = 1'b0; tick();
   endtask

   // Start a conversion and stop after the given number of CONV cycles
   task automatic start_conv(input int conv_cycles);
      sw_data = 16'd300; btn_enter = 1'b1; tick(); btn_enter = 1'b0; tick();
      sw_data = 16'd200; sw_op = 2'b10; btn_enter = 1'b1; tick(); btn_enter = 1'b0;
      repeat (conv_cycles) tick();
   endtask

   task automatic test_clear_conv();
      run_op(16'd77, 16'd11, 2'b00, 0, "pre_clear");
      start_conv(16);
      nvec++;
      if (state_o !== 3'd3 || busy !== 1'b1) begin
         nerr++;
         $display("FAIL clear_pre: got st=%0d busy=%b want st=3 busy=1", state_o, busy);
      end
      btn_clear = 1'b1; btn_enter = 1'b1; sw_data = 16'hABCD; tick();
      btn_clear = 1'b0; btn_enter = 1'b0;
      nvec++;
      if ({state_o, alu_a, alu_b, alu_op, bcd_out, div_err, busy, done} !== '0) begin
         nerr++;
         $display("FAIL clear_conv: got st=%0d a=%h b=%h op=%0d bcd=%h err=%b busy=%b done=%b want all 0",
                  state_o, alu_a, alu_b, alu_op, bcd_out, div_err, busy, done);
      end
      repeat (40) tick();
      nvec++;
      if (state_o !== 3'd0 || bcd_out !== '0 || done !== 1'b0) begin
         nerr++;
         $display("FAIL clear_abort: got st=%0d bcd=%h done=%b want st=0 bcd=0 done=0",
                  state_o, bcd_out, done);
      end
      model_bcd = '0;
   endtask

   task automatic test_async_reset();
      run_op(16'd4096, 16'd3, 2'b01, 0, "pre_reset");
      start_conv(10);
      #2;
      rst_n = 1'b0;
      #1;
      nvec++;
      if ({state_o, alu_a, alu_b, alu_op, bcd_out, div_err, busy, done} !== '0) begin
         nerr++;
         $display("FAIL async_reset: got st=%0d a=%h b=%h op=%0d bcd=%h err=%b busy=%b done=%b want all 0",
                  state_o, alu_a, alu_b, alu_op, bcd_out, div_err, busy, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      model_bcd = '0;
      run_op(16'd12, 16'd34, 2'b00, 0, "post_reset");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_press_in_conv();
      test_random();
      test_hold();
      test_clear_conv();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencer that time-shares the board switch bank to load the 16-bit operands A and B and the 2-bit op code into the combinational alu_32bit_2 datapath. It registers the 32-bit ALU result and converts it to 10-digit packed BCD with a serial double-dabble engine. It sits between the debounced board inputs (switches, enter/clear buttons) and the 7-segment display driver, and owns all operand and result registers.

Parameters:
DATA_W, 16, operand width driven to the ALU
RES_W, 32, ALU result width; also the double-dabble shift count
BCD_DIGITS, 10, number of BCD digits produced (4*BCD_DIGITS output bits)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
sw_data  in  DATA_W  operand switches, already synchronous to clk
sw_op  in  2  op select switches (00 add, 01 abs-diff, 10 mul, 11 max/min divide)
btn_enter  in  1  debounced, synchronous, level-high enter button
btn_clear  in  1  debounced, synchronous, level-high clear button
alu_a  out  DATA_W  registered operand A to the ALU
alu_b  out  DATA_W  registered operand B to the ALU
alu_op  out  2  registered op select to the ALU
alu_result  in  RES_W  combinational ALU result
bcd_out  out  4*BCD_DIGITS  packed BCD result; digit 0 in bits [3:0]
state_o  out  3  current state encoding, for LEDs
busy  out  1  high in EXEC and CONV
done  out  1  high in DONE
div_err  out  1  divide-by-zero flag for the displayed result

Behaviour:
- Reset (rst_n=0, async): state IDLE; alu_a, alu_b, alu_op, bcd_out, div_err, internal result register, shift counter, and enter-edge register all 0; busy=0, done=0.
- Enter press = btn_enter & ~enter_q, where enter_q is btn_enter registered. A held button gives exactly one press.
- States and encodings: IDLE=0, WAIT_B=1, EXEC=2, CONV=3, DONE=4. Unused encodings go to IDLE on the next clock.
- IDLE: on press, alu_a<=sw_data, go to WAIT_B.
- WAIT_B: on press, alu_b<=sw_data, alu_op<=sw_op, go to EXEC.
- EXEC (1 cycle): res_reg<=alu_result.
  - If alu_op==2'b11 and alu_result==32'hFFFF_FFFF: set div_err=1, set bcd_out to all 4'hF (blank code), go to DONE with conversion skipped.
  - Otherwise: div_err<=0, clear the BCD shift register, counter<=0, go to CONV.
  - This value cannot come from a valid op-11 divide, so the test is unambiguous.
- CONV: exactly RES_W (32) cycles. Each cycle, in order:
  - add 3 to every BCD digit >=5;
  - shift {bcd, res_reg} left 1;
  - increment the counter.
  - After the 32nd shift, load bcd_out from the shift register and go to DONE.
  - bcd_out holds its previous value throughout CONV and never shows partial results.
- Latency: the WAIT_B press cycle is N. EXEC is N+1, CONV is N+2..N+33, and done=1 from N+34. On div_err, done=1 from N+2.
- DONE: bcd_out and div_err hold. On press, alu_a<=sw_data and go to WAIT_B (chained entry); bcd_out keeps the old value until the next conversion completes.
- Presses in EXEC or CONV are ignored and not queued.
- btn_clear in any state: next state IDLE. alu_a, alu_b, alu_op, bcd_out, div_err, and the counter go to 0. Clear wins over a same-cycle press.
- Clear or reset during CONV aborts the conversion; no partial bcd_out is ever loaded.
- Width rules:
  - 32-bit input max is 4294967295, so 10 digits suffice and never overflow.
  - Op-10 max is 65535*65535 = 4294836225, which cannot collide with 32'hFFFF_FFFF.
  - The shift register is 4*BCD_DIGITS+RES_W bits.

Test Plan:
- Reset, then press A=25, press B=17 with op=00 -> EXEC then 32 CONV cycles; done rises exactly 34 cycles after the B press; bcd_out=40'h00_0000_0042; div_err=0.
- A=5, B=9, op=01 -> bcd_out=...0004. Then chained press in DONE with A=100, B=7, op=11 -> bcd_out=...0014.
- A=65535, B=65535, op=10 -> bcd_out=40'h42_9483_6225.
- A=1234, B=0, op=11 -> ALU returns FFFF_FFFF; div_err=1, bcd_out all F, done asserted 2 cycles after the B press. Repeat with op=10 and B=0 -> result 0, div_err=0.
- Hold btn_enter high for 10 cycles in IDLE -> only A is loaded and state stays WAIT_B. Press enter during CONV -> ignored; the result is unchanged.
- Assert btn_clear during CONV at cycle 16 together with a press -> IDLE next cycle, all outputs 0. Assert rst_n=0 mid-CONV asynchronously -> outputs 0 immediately, with no clock edge needed.
